// File: rtl/product_accumulator_if.sv
// rtl/product_accumulator_if.sv - handshake bundle between multiplier, accumulator and consumer
// Purpose: groups the run-control, product stream and result handshake of product_accumulator.
// Signals:
//   i_start, i_len               run request and its product count
//   i_prod_valid, i_product      incoming signed product, o_prod_ready back-pressure
//   o_result_valid, o_result     held signed sum, taken with i_result_ready
//   o_busy, o_overflow           run in progress, sticky signed overflow of this run
// Modports: master drives the inputs (stimulus side), slave is the accumulator.
interface product_accumulator_if #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 80,
  parameter int CNT_W  = 8
);
  logic                     i_start;
  logic [CNT_W-1:0]         i_len;
  logic                     i_prod_valid;
  logic signed [PROD_W-1:0] i_product;
  logic                     o_prod_ready;
  logic                     o_result_valid;
  logic signed [ACC_W-1:0]  o_result;
  logic                     i_result_ready;
  logic                     o_busy;
  logic                     o_overflow;

  modport master (
    output i_start, i_len, i_prod_valid, i_product, i_result_ready,
    input  o_prod_ready, o_result_valid, o_result, o_busy, o_overflow
  );

  modport slave (
    input  i_start, i_len, i_prod_valid, i_product, i_result_ready,
    output o_prod_ready, o_result_valid, o_result, o_busy, o_overflow
  );
endinterface

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums a programmed count of signed products into a wide accumulator
// Purpose: MAC back end for the 32x32 signed sequential multiplier. A run starts in IDLE with
//   i_start, accepts i_len products (one per clock while accumulating) and presents the sum on a
//   held result handshake.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      product_accumulator_if.slave (start/len, product stream, result, busy, overflow)
// Configuration: define PRODUCT_ACC_SATURATE_EN to clamp the accumulator on signed overflow;
//   otherwise it wraps in two's complement. o_overflow is identical in both builds.
module product_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 80,
  parameter int CNT_W  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  product_accumulator_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic [CNT_W-1:0]        cnt_q;
  logic                    ovf_q;
  logic                    add_ovf;
  logic                    start_take;
  logic                    xfer;

  // i_start only counts in IDLE; this also drops a start coincident with the result handoff.
  assign start_take = (state_q == S_IDLE) && bus.i_start;
  assign xfer       = (state_q == S_ACCUM) && bus.i_prod_valid;

  // Signed width cast sign-extends the product into the accumulator width.
  assign prod_ext = ACC_W'(bus.i_product);
  assign sum      = acc_q + prod_ext;
  assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    acc_d = sum;
`ifdef PRODUCT_ACC_SATURATE_EN
    // Operand signs are equal on overflow, so the accumulator sign picks the rail.
    if (add_ovf) begin
      acc_d = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d = (bus.i_len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (xfer && (cnt_q == CNT_W'(1))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.i_result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (start_take) begin
      acc_q <= '0;
      cnt_q <= bus.i_len;
      ovf_q <= 1'b0;
    end else if (xfer) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q - CNT_W'(1);
      if (add_ovf) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // All outputs come from registers; acc_q is cleared only by start or reset, so the
  // result stays visible in IDLE after the handoff.
  assign bus.o_prod_ready   = (state_q == S_ACCUM);
  assign bus.o_result_valid = (state_q == S_DONE);
  assign bus.o_result       = acc_q;
  assign bus.o_busy         = (state_q != S_IDLE);
  assign bus.o_overflow     = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - randomized self-checking bench for product_accumulator
module tb_product_accumulator;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic [7:0]         len_in = '0;
  logic               pvalid = 1'b0;
  logic signed [63:0] prod = '0;
  logic               rready = 1'b0;

  always #5 clk = ~clk;

  product_accumulator_if #(.PROD_W(64), .ACC_W(80), .CNT_W(8)) bus80();
  product_accumulator_if #(.PROD_W(64), .ACC_W(64), .CNT_W(8)) bus64();

  assign bus80.i_start        = start;
  assign bus80.i_len          = len_in;
  assign bus80.i_prod_valid   = pvalid;
  assign bus80.i_product      = prod;
  assign bus80.i_result_ready = rready;
  assign bus64.i_start        = start;
  assign bus64.i_len          = len_in;
  assign bus64.i_prod_valid   = pvalid;
  assign bus64.i_product      = prod;
  assign bus64.i_result_ready = rready;

  product_accumulator #(.PROD_W(64), .ACC_W(80), .CNT_W(8)) dut80 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus80)
  );

  product_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(8)) dut64 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus64)
  );

  int vectors = 0;
  int miscompares = 0;
  logic signed [63:0] prods [256];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer sum, then wrap or clamp into a w-bit signed range.
  function automatic logic signed [127:0] model(input int w, input int n, output logic ovf);
    logic signed [127:0] one, acc, s, maxv, minv, span;
    one  = 128'sd1;
    maxv = (one <<< (w - 1)) - one;
    minv = -(one <<< (w - 1));
    span = one <<< w;
    acc  = '0;
    ovf  = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = acc + 128'($signed(prods[i]));
      if (s > maxv || s < minv) begin
        ovf = 1'b1;
`ifdef PRODUCT_ACC_SATURATE_EN
        s = (s > maxv) ? maxv : minv;
`else
        s = (s > maxv) ? s - span : s + span;
`endif
      end
      acc = s;
    end
    return acc;
  endfunction

  function automatic logic [127:0] r80();
    return 128'($signed(bus80.o_result));
  endfunction

  function automatic logic [127:0] r64();
    return 128'($signed(bus64.o_result));
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},  {127'd0, bus80.o_busy | bus64.o_busy}, 128'd0);
    check({tag, "_valid"}, {127'd0, bus80.o_result_valid | bus64.o_result_valid}, 128'd0);
    check({tag, "_ready"}, {127'd0, bus80.o_prod_ready | bus64.o_prod_ready}, 128'd0);
    check({tag, "_ovf"},   {127'd0, bus80.o_overflow | bus64.o_overflow}, 128'd0);
    check({tag, "_res80"}, r80(), 128'd0);
    check({tag, "_res64"}, r64(), 128'd0);
  endtask

  // One full run of n products from prods[]; gaps of gap_lo..gap_hi idle cycles before each
  // product; result consumer stalls for `stall` cycles while start and stray products are offered.
  task automatic run(input int n, input int gap_lo, input int gap_hi, input int stall);
    logic signed [127:0] e80, e64;
    logic o80, o64;
    int g;
    e80 = model(80, n, o80);
    e64 = model(64, n, o64);
    @(negedge clk);
    start  = 1'b1;
    len_in = n[7:0];
    @(negedge clk);
    start = 1'b0;
    check("busy", {127'd0, bus80.o_busy}, 128'd1);
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(gap_hi, gap_lo);
      for (int k = 0; k < g; k++) begin
        check("ready_gap", {127'd0, bus80.o_prod_ready}, 128'd1);
        @(negedge clk);
      end
      pvalid = 1'b1;
      prod   = prods[i];
      check("ready", {127'd0, bus80.o_prod_ready & bus64.o_prod_ready}, 128'd1);
      @(negedge clk);
      pvalid = 1'b0;
    end
    check("valid80", {127'd0, bus80.o_result_valid}, 128'd1);
    check("valid64", {127'd0, bus64.o_result_valid}, 128'd1);
    check("result80", r80(), e80);
    check("result64", r64(), e64);
    check("ovf80", {127'd0, bus80.o_overflow}, {127'd0, o80});
    check("ovf64", {127'd0, bus64.o_overflow}, {127'd0, o64});
    check("ready_done", {127'd0, bus80.o_prod_ready}, 128'd0);
    for (int k = 0; k < stall; k++) begin
      start  = 1'b1;
      pvalid = 1'b1;
      prod   = {$urandom, $urandom};
      rready = 1'b0;
      @(negedge clk);
      check("stall_valid", {127'd0, bus80.o_result_valid}, 128'd1);
      check("stall_res80", r80(), e80);
      check("stall_res64", r64(), e64);
    end
    pvalid = 1'b0;
    rready = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    start  = 1'b0;
    check("handoff_valid", {127'd0, bus80.o_result_valid | bus64.o_result_valid}, 128'd0);
    check("handoff_busy", {127'd0, bus80.o_busy | bus64.o_busy}, 128'd0);
    check("idle_res80", r80(), e80);
    @(negedge clk);
    check("idle_hold", {127'd0, bus80.o_busy}, 128'd0);
    check("idle_res64", r64(), e64);
  endtask

  function automatic logic signed [63:0] rand_prod();
    logic signed [63:0] p;
    if ($urandom_range(1, 0) == 1) p = {$urandom, $urandom};
    else p = 64'($signed($urandom_range(2000, 0))) - 64'sd1000;
    return p;
  endfunction

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;

    // products of 12/13 and -12
    prods[0] = 64'sd156; prods[1] = 64'sd144; prods[2] = -64'sd144;
    run(3, 0, 0, 0);
    // empty run
    run(0, 0, 0, 0);
    // gapped valid
    prods[0] = 64'sd7; prods[1] = -64'sd9;
    run(2, 5, 5, 0);
    // long result stall
    prods[0] = -64'sd3; prods[1] = 64'sd40; prods[2] = 64'sd1;
    run(3, 0, 1, 10);
    // positive overflow of the 64-bit accumulator
    prods[0] = 64'sh7FFF_FFFF_FFFF_FFFF; prods[1] = 64'sd1;
    run(2, 0, 0, 0);
    // negative overflow, then continue adding
    prods[0] = 64'sh8000_0000_0000_0000; prods[1] = -64'sd1; prods[2] = 64'sd5;
    run(3, 0, 0, 1);

    // reset after one of four products
    @(negedge clk);
    start  = 1'b1;
    len_in = 8'd4;
    @(negedge clk);
    start  = 1'b0;
    pvalid = 1'b1;
    prod   = 64'sd100;
    @(negedge clk);
    pvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_idle_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    prods[0] = 64'sd5;
    run(1, 0, 0, 0);

    // maximum length
    for (int i = 0; i < 255; i++) prods[i] = rand_prod();
    run(255, 0, 0, 0);

    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(8, 1);
      for (int i = 0; i < n; i++) prods[i] = rand_prod();
      run(n, 0, 3, $urandom_range(3, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
